// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operation sequencer.
// ALU_FWD_EN adds the forward flag to the request entry.
package alu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned SEL_W  = 3;

    typedef enum logic [SEL_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_NOR = 3'd5,
        ALU_SHL = 3'd6,
        ALU_GT  = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } seq_state_e;

    typedef struct packed {
`ifdef ALU_FWD_EN
        logic              fwd;
`endif
        alu_op_e           sel;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] a;
    } req_entry_t;

    localparam int unsigned ENTRY_W = $bits(req_entry_t);

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit to tell full from empty.
module alu_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the 8-bit combinational ALU: FIFO-buffered requests, registered
// operands, captured results on a valid/ready response port. ALU_FWD_EN enables req_fwd.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SEQ_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_a,
    input  logic [7:0]       req_b,
    input  logic [2:0]       req_sel,
    input  logic             req_fwd,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [2:0]       alu_sel,
    input  logic [7:0]       alu_out,
    input  logic             alu_zero,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic [SEQ_W-1:0] rsp_seq
);

    localparam logic [SEQ_W-1:0] SEQ_ONE = {{(SEQ_W-1){1'b0}}, 1'b1};

    seq_state_e        state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_carry_q, rsp_carry_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [DATA_W-1:0] last_result_q, last_result_d;

    req_entry_t        entry_in;
    req_entry_t        head;
    logic [ENTRY_W-1:0] head_bits;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;

    always_comb begin
        entry_in     = '0;
        entry_in.a   = req_a;
        entry_in.b   = req_b;
        entry_in.sel = alu_op_e'(req_sel);
`ifdef ALU_FWD_EN
        entry_in.fwd = req_fwd;
`endif
    end

`ifndef ALU_FWD_EN
    // Forwarding is compiled out; the flag is accepted on the port but never stored.
    logic unused_req_fwd;
    assign unused_req_fwd = req_fwd;
`endif

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_valid),
        .push_data (entry_in),
        .pop       (fifo_pop),
        .pop_data  (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head      = req_entry_t'(head_bits);
    assign req_ready = !fifo_full;

    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_sel_d     = alu_sel_q;
        rsp_data_d    = rsp_data_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_carry_d   = rsp_carry_q;
        rsp_valid_d   = rsp_valid_q;
        seq_d         = seq_q;
        last_result_d = last_result_q;
        fifo_pop      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_data_d    = alu_out;
                rsp_zero_d    = alu_zero;
                rsp_carry_d   = alu_carry;
                last_result_d = alu_out;
                rsp_valid_d   = 1'b1;
                state_d       = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    seq_d       = seq_q + SEQ_ONE;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = S_EXEC;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pop from either IDLE or RESP loads the ALU operand registers the same way.
        if (fifo_pop) begin
            alu_a_d   = head.a;
            alu_b_d   = head.b;
            alu_sel_d = head.sel;
`ifdef ALU_FWD_EN
            if (head.fwd) begin
                alu_a_d = last_result_q;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_sel_q     <= '0;
            rsp_data_q    <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_carry_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            seq_q         <= '0;
            last_result_q <= '0;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_sel_q     <= alu_sel_d;
            rsp_data_q    <= rsp_data_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_carry_q   <= rsp_carry_d;
            rsp_valid_q   <= rsp_valid_d;
            seq_q         <= seq_d;
            last_result_q <= last_result_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_seq   = seq_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU attached to its alu_* port.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_a = '0;
    logic [7:0] req_b = '0;
    logic [2:0] req_sel = '0;
    logic       req_fwd = 1'b0;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_zero;
    logic       alu_carry;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_zero;
    logic       rsp_carry;
    logic [3:0] rsp_seq;

    logic       rsp_ready_man = 1'b0;
    logic       bp_rand = 1'b0;
    logic       rnd_ready = 1'b0;

    typedef struct packed {
        logic [7:0] data;
        logic       zero;
        logic       carry;
    } exp_t;

    exp_t        exp_q[$];
    logic [3:0]  exp_seq = '0;
    int unsigned n_rsp = 0;
    logic [7:0]  model_last = '0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;

    assign rsp_ready = bp_rand ? rnd_ready : rsp_ready_man;
    always @(posedge clk) rnd_ready <= 1'($urandom_range(0, 1));

    alu_op_sequencer #(
        .DEPTH (4),
        .SEQ_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .req_fwd   (req_fwd),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_zero  (alu_zero),
        .alu_carry (alu_carry),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .rsp_carry (rsp_carry),
        .rsp_seq   (rsp_seq)
    );

    // Returns {carry, zero, out}; carry is only produced by ADD.
    function automatic logic [9:0] ref_alu(input logic [2:0] sel, input logic [7:0] a,
                                           input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] o;
        logic       c;
        c = 1'b0;
        s = '0;
        case (sel)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; o = s[7:0]; c = s[8]; end
            3'd1: o = a - b;
            3'd2: o = a & b;
            3'd3: o = a | b;
            3'd4: o = a ^ b;
            3'd5: o = ~(a | b);
            3'd6: o = {a[6:0], 1'b0};
            default: o = (a > b) ? 8'd1 : 8'd0;
        endcase
        return {c, (o == 8'd0), o};
    endfunction

    logic [9:0] alu_r;
    always_comb begin
        alu_r     = ref_alu(alu_sel, alu_a, alu_b);
        alu_out   = alu_r[7:0];
        alu_zero  = alu_r[8];
        alu_carry = alu_r[9];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_seq = '0;
            n_rsp   = 0;
        end else if (rsp_valid && rsp_ready) begin
            check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_zero", 32'(rsp_zero), 32'(e.zero));
                check("rsp_carry", 32'(rsp_carry), 32'(e.carry));
            end
            check("rsp_seq", 32'(rsp_seq), 32'(exp_seq));
            exp_seq = exp_seq + 4'd1;
            n_rsp++;
        end
    end

    task automatic push_op(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                           input logic fwd, input int unsigned budget, output bit accepted);
        logic [7:0] a_eff;
        logic [9:0] r;
        exp_t       e;
        accepted  = 1'b0;
        req_valid = 1'b1;
        req_sel   = sel;
        req_a     = a;
        req_b     = b;
        req_fwd   = fwd;
        for (int unsigned i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req_ready) begin
                accepted = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (accepted) begin
            a_eff = a;
`ifdef ALU_FWD_EN
            if (fwd) a_eff = model_last;
`endif
            r          = ref_alu(sel, a_eff, b);
            model_last = r[7:0];
            e.data     = r[7:0];
            e.zero     = r[8];
            e.carry    = r[9];
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic push_ok(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                           input logic fwd);
        bit acc;
        push_op(sel, a, b, fwd, 100, acc);
        check("push_accepted", 32'(acc), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_seq", 32'(rsp_seq), 32'd0);
        model_last = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n;
        n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         acc;
        int unsigned n;
        logic [7:0] held;

        #1;
        check("init_rsp_valid", 32'(rsp_valid), 32'd0);
        check("init_req_ready", 32'(req_ready), 32'd1);
        check("init_alu_a", 32'(alu_a), 32'd0);
        check("init_alu_sel", 32'(alu_sel), 32'd0);
        check("init_rsp_data", 32'(rsp_data), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset while a response is being held.
        rsp_ready_man = 1'b0;
        push_ok(3'd0, 8'h11, 8'h22, 1'b0);
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t1_rsp_pending", 32'(rsp_valid), 32'd1);
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        check("t1_idle_after_rst", 32'(rsp_valid), 32'd0);
        check("t1_ready_after_rst", 32'(req_ready), 32'd1);

        // ADD with carry-out and two-cycle latency.
        rsp_ready_man = 1'b1;
        push_ok(3'd0, 8'hFF, 8'h01, 1'b0);
        check("t2_lat_e0", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        check("t2_lat_e1", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        check("t2_lat_e2", 32'(rsp_valid), 32'd1);
        drain(50);

        // Fill under backpressure: 1 in flight + DEPTH queued, sixth refused.
        do_reset();
        rsp_ready_man = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push_op(3'd1, 8'(20 + i * 10), 8'(i + 1), 1'b0, 1, acc);
            check("t3_accept", 32'(acc), (i < 5) ? 32'd1 : 32'd0);
        end
        check("t3_ready_full", 32'(req_ready), 32'd0);
        held = rsp_data;
        repeat (4) @(posedge clk);
        #1;
        check("t3_data_stable", 32'(rsp_data), 32'(held));
        check("t3_valid_held", 32'(rsp_valid), 32'd1);
        rsp_ready_man = 1'b1;
        drain(100);
        check("t3_rsp_count", n_rsp, 32'd5);

        // Forwarding chain: expected value depends on build.
        push_ok(3'd0, 8'd3, 8'd4, 1'b0);
        push_ok(3'd1, 8'd9, 8'd2, 1'b1);
        drain(50);

        // Flag corner cases.
        push_ok(3'd7, 8'd5, 8'd5, 1'b0);
        push_ok(3'd7, 8'd6, 8'd5, 1'b0);
        push_ok(3'd6, 8'h80, 8'h00, 1'b0);
        push_ok(3'd1, 8'h02, 8'h05, 1'b0);
        push_ok(3'd2, 8'hF0, 8'h3C, 1'b0);
        push_ok(3'd3, 8'hF0, 8'h0F, 1'b0);
        push_ok(3'd4, 8'hAA, 8'hAA, 1'b0);
        push_ok(3'd5, 8'h0F, 8'h30, 1'b0);
        push_ok(3'd0, 8'h7F, 8'h01, 1'b0);
        drain(100);

        // Sequence tag wrap with random backpressure and random forwarding.
        do_reset();
        bp_rand = 1'b1;
        for (int i = 0; i < 17; i++) begin
            push_ok(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                    1'($urandom_range(0, 1)));
        end
        drain(400);
        bp_rand       = 1'b0;
        rsp_ready_man = 1'b0;
        @(posedge clk);
        #1;
        check("t6_rsp_count", n_rsp, 32'd17);
        check("t6_seq_wrapped", 32'(rsp_seq), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
